keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Scans a 4x4 active-low matrix keypad. Strobes rows one at a time, synchronises and debounces the column returns.
//   Emits one 8-bit location code per debounced key press.
//   Sits directly upstream of the keypad digit-lookup stage; location feeds its location input unchanged.
//   Location code = {row_n[3:0] driven, col_n[3:0] sensed}, each one-hot active-low.
//   Row order: row0=4'b0111 .. row3=4'b1110. Column order: col0=4'b0111 .. col3=4'b1110.
// PARAMETERS
//   SETTLE_CYCLES    16      cycles a row is driven before its columns are sampled; must be >=3 (covers 2FF sync)
//   DEBOUNCE_CYCLES  100000  consecutive stable cycles needed to accept a press or a release (2 ms @ 50 MHz)
//   CNT_W            17      counter width; must hold max(SETTLE_CYCLES, DEBOUNCE_CYCLES)
// PORTS
//   clk        in   1  system clock, all logic on rising edge
//   reset      in   1  synchronous, active-high
//   col_n      in   4  raw keypad column lines, pulled up, active-low, asynchronous
//   row_n      out  4  row drive, exactly one bit low at all times
//   location   out  8  last accepted key code; held until the next accepted press
//   key_valid  out  1  one-cycle pulse, coincident with the first cycle location shows a new code
//   key_down   out  1  high from acceptance until release is debounced
// BEHAVIOUR
//   Reset (sampled reset=1): row_n=4'b0111, location=8'hFF, key_valid=0, key_down=0, counters=0, state=SCAN, sync flops=4'hF.
//   col_n passes through a 2-flop synchroniser; all decisions use the synchronised value colS.
//   FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
//   SCAN
//     - Hold row for SETTLE_CYCLES, then sample colS.
//     - colS==4'hF (no key) or more than one bit low: advance to the next row, wrapping row3->row0, and restart settle count.
//     - Exactly one bit low: capture cand={row_n,colS}, clear counter, go to DEBOUNCE. The row is frozen.
//   DEBOUNCE
//     - Each cycle {row_n,colS}==cand: increment counter.
//     - Any mismatch (bounce, release, second column): return to SCAN on the next row, nothing emitted.
//     - Counter reaches DEBOUNCE_CYCLES-1 while still matching: next cycle location<=cand, key_valid=1, key_down=1, go to PRESSED.
//   PRESSED
//     - Row stays frozen.
//     - colS==4'hF: clear counter, go to RELEASE.
//     - Other changes, including a second key, are ignored. No auto-repeat.
//   RELEASE
//     - colS!=4'hF: return to PRESSED (release bounce).
//     - DEBOUNCE_CYCLES consecutive cycles of 4'hF: key_down<=0, go to SCAN on the next row.
//   Press latency (key stable at pins): at most 2 (sync) + 4*SETTLE_CYCLES + DEBOUNCE_CYCLES + 1 cycles to key_valid.
//   key_valid is never high for 2 consecutive cycles. Exactly one pulse per press/release pair.
//   Simultaneous keys:
//     - Two keys in the same row are rejected.
//     - Keys in different rows: the first row scanned wins.
//   Reset mid-operation: reset values are applied on the next edge. Any pending candidate is discarded and no pulse is produced.
//   Counters saturate and never wrap.
//   location never holds a non-one-hot nibble except the reset value 8'hFF.
// STRUCTURE
//   keypad_pkg:
//     - state enum {SCAN,DEBOUNCE,PRESSED,RELEASE}
//     - ROW_FIRST=4'b0111, NO_KEY=4'hF, LOC_RESET=8'hFF
//     - function onehot_low(4b)->1b
//   Sub-module sync_2ff (parameterised width) for col_n.
//   Row rotation: right-rotate of row_n with a 1 fill, i.e. {1'b1,row_n[3:1]} with row3 wrapping to ROW_FIRST.
// TESTING  (bench params: SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8)
//   1 Key row1/col2 held 60 cycles, then released -> exactly one key_valid, location=8'hBD (digit 6), key_down falls >=8 cycles after release.
//   2 Key row3/col1 toggling with period 6 cycles for 50 cycles -> no key_valid, location stays 8'hFF.
//   3 Row0 with col0+col1 low (model returns 4'b0011) -> no key_valid; row_n keeps cycling 0111,1011,1101,1110,0111.
//   4 Press row0/col3, release, then press row3/col0 -> two pulses, locations 8'h7E then 8'hE7; key_down low between them.
//   5 Press held, reset asserted for 1 cycle mid-DEBOUNCE -> next cycle row_n=0111, location=8'hFF, key_down=0, no pulse from the aborted candidate.
//   6 Key held 500 cycles, release bounces 3 times for 3 cycles each -> single key_valid, key_down high until 8 clean release cycles.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_pkg : shared types, constants and helpers for the 4x4 keypad scanner
// Revision   : 1.0
// ---------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] ROW_FIRST = 4'b0111;
  localparam logic [3:0] NO_KEY    = 4'hF;
  localparam logic [7:0] LOC_RESET = 8'hFF;

  // True when exactly one line of an active-low nibble is pulled low.
  function automatic logic onehot_low(input logic [3:0] v);
    logic [3:0] a;
    a = ~v;
    return (a != 4'd0) && ((a & (a - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [3:0] next_row(input logic [3:0] row);
    return (row == 4'b1110) ? ROW_FIRST : {1'b1, row[3:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_2ff : two-flop synchroniser for asynchronous inputs, preset on reset
// Revision : 1.0
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_scanner : 4x4 active-low matrix scanner with debounce, one code/press
// Revision       : 1.0
// ---------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [7:0] location,
  output logic       key_valid,
  output logic       key_down
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cand_q, cand_d;
  logic [7:0]       loc_q, loc_d;
  logic             valid_q, valid_d;
  logic             down_q, down_d;

  logic [3:0]       col_s;
  logic [CNT_W-1:0] cnt_inc;

  sync_2ff #(
    .WIDTH     (4),
    .RESET_VAL (NO_KEY)
  ) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d     (col_n),
    .q     (col_s)
  );

  // Saturating increment keeps a long-held key from wrapping the counter.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    loc_d   = loc_q;
    valid_d = 1'b0;
    down_d  = down_q;

    case (state_q)
      SCAN: begin
        if (cnt_q >= SETTLE_LAST) begin
          cnt_d = '0;
          if (onehot_low(col_s)) begin
            cand_d  = {row_q, col_s};
            state_d = DEBOUNCE;
          end else begin
            row_d = next_row(row_q);
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      DEBOUNCE: begin
        if ({row_q, col_s} == cand_q) begin
          if (cnt_q >= DEB_LAST) begin
            loc_d   = cand_q;
            valid_d = 1'b1;
            down_d  = 1'b1;
            cnt_d   = '0;
            state_d = PRESSED;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          row_d   = next_row(row_q);
          cnt_d   = '0;
          state_d = SCAN;
        end
      end

      PRESSED: begin
        if (col_s == NO_KEY) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        if (col_s != NO_KEY) begin
          state_d = PRESSED;
        end else if (cnt_q >= DEB_LAST) begin
          down_d  = 1'b0;
          row_d   = next_row(row_q);
          cnt_d   = '0;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = SCAN;
        row_d   = ROW_FIRST;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN;
      row_q   <= ROW_FIRST;
      cnt_q   <= '0;
      cand_q  <= LOC_RESET;
      loc_q   <= LOC_RESET;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      loc_q   <= loc_d;
      valid_q <= valid_d;
      down_q  <= down_d;
    end
  end

  assign row_n     = row_q;
  assign location  = loc_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_keypad_scanner : keypad matrix model driving keypad_scanner, self-checking
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SETTLE = 4;
  localparam int DEB    = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [7:0] location;
  logic       key_valid;
  logic       key_down;

  logic [15:0] keys = '0;   // keys[r*4+c] set while key (row r, col c) is held

  int   n_cmp = 0;
  int   n_mis = 0;
  int   pulses = 0;
  int   dbl = 0;
  logic prev_v = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SETTLE_CYCLES   (SETTLE),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (17)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col_n     (col_n),
    .row_n     (row_n),
    .location  (location),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  // Matrix: a column reads low when any held key on a currently driven row shorts it.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && (row_n[3-r] == 1'b0)) col_n[3-c] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) begin
      pulses++;
      if (prev_v) dbl++;
    end
    prev_v = key_valid;
  end

  function automatic logic [3:0] rowc(input int i);
    logic [3:0] b;
    b = 4'b1000 >> i;
    return ~b;
  endfunction

  function automatic logic [7:0] code(input int r, input int c);
    return {rowc(r), rowc(c)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  task automatic wait_down_low(input string tag, output int took);
    took = 0;
    while (key_down && took < 60) begin
      cyc(1);
      took++;
    end
    chk(tag, key_down, 1'b0);
  endtask

  initial begin
    int p0, took, idx, changes, r, c, c2, kind, hold;
    logic [3:0] prev;
    logic [7:0] exp_loc;

    // Reset state
    reset = 1'b1;
    cyc(2);
    chk("rst_row", row_n, 4'b0111);
    chk("rst_loc", location, 8'hFF);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_down", key_down, 1'b0);
    reset = 1'b0;

    // Single press row1/col2, held then released
    p0 = pulses;
    keys[1*4+2] = 1'b1;
    cyc(60);
    chk("t1_pulses", pulses - p0, 1);
    chk("t1_loc", location, 8'hBD);
    chk("t1_down", key_down, 1'b1);
    keys = '0;
    wait_down_low("t1_fall", took);
    chk("t1_fall_ge8", took >= DEB, 1'b1);
    chk("t1_loc_held", location, 8'hBD);

    // Bouncing key never accepted
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 50; i++) begin
      keys[3*4+1] = ((i % 6) < 3);
      cyc(1);
    end
    keys = '0;
    cyc(20);
    chk("t2_pulses", pulses - p0, 0);
    chk("t2_loc", location, 8'hFF);

    // Two keys in one row rejected, scan keeps rotating
    do_reset();
    p0 = pulses;
    keys[0] = 1'b1;
    keys[1] = 1'b1;
    prev = row_n;
    chk("t3_start", prev, 4'b0111);
    idx = 0;
    changes = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (row_n !== prev) begin
        chk("t3_rot", row_n, rowc((idx + 1) % 4));
        idx = (idx + 1) % 4;
        prev = row_n;
        changes++;
      end
    end
    chk("t3_changes", changes >= 5, 1'b1);
    chk("t3_pulses", pulses - p0, 0);
    keys = '0;

    // Two sequential presses
    do_reset();
    p0 = pulses;
    keys[0*4+3] = 1'b1;
    cyc(40);
    chk("t4_p1", pulses - p0, 1);
    chk("t4_loc1", location, 8'h7E);
    keys = '0;
    wait_down_low("t4_rel1", took);
    keys[3*4+0] = 1'b1;
    cyc(40);
    chk("t4_p2", pulses - p0, 2);
    chk("t4_loc2", location, 8'hE7);
    keys = '0;
    wait_down_low("t4_rel2", took);
    cyc(10);

    // Reset mid-debounce: align to the start of a row0 window first
    p0 = pulses;
    prev = row_n;
    took = 0;
    while (!(row_n == 4'b0111 && prev != 4'b0111) && took < 64) begin
      prev = row_n;
      cyc(1);
      took++;
    end
    chk("t5_align", took < 64, 1'b1);
    keys[0] = 1'b1;
    cyc(8);
    reset = 1'b1;
    keys = '0;
    cyc(1);
    chk("t5_row", row_n, 4'b0111);
    chk("t5_loc", location, 8'hFF);
    chk("t5_down", key_down, 1'b0);
    chk("t5_valid", key_valid, 1'b0);
    reset = 1'b0;
    cyc(30);
    chk("t5_pulses", pulses - p0, 0);

    // Long hold with bouncing release
    p0 = pulses;
    r = int'($urandom_range(0, 3));
    c = int'($urandom_range(0, 3));
    keys[r*4+c] = 1'b1;
    cyc(500);
    chk("t6_pulses", pulses - p0, 1);
    chk("t6_loc", location, code(r, c));
    for (int i = 0; i < 3; i++) begin
      keys = '0;
      cyc(3);
      keys[r*4+c] = 1'b1;
      cyc(3);
    end
    chk("t6_down_bounce", key_down, 1'b1);
    chk("t6_pulses_bounce", pulses - p0, 1);
    keys = '0;
    wait_down_low("t6_fall", took);
    chk("t6_fall_ge8", took >= DEB, 1'b1);
    cyc(20);
    chk("t6_pulses_end", pulses - p0, 1);

    // Randomised presses against the abstract model
    exp_loc = location;
    for (int it = 0; it < 12; it++) begin
      p0 = pulses;
      kind = int'($urandom_range(0, 2));
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      c2 = (c + 1 + int'($urandom_range(0, 2))) % 4;
      hold = (kind == 1) ? int'($urandom_range(1, 5)) : int'($urandom_range(40, 80));
      keys[r*4+c] = 1'b1;
      if (kind == 2) keys[r*4+c2] = 1'b1;
      cyc(hold);
      keys = '0;
      if (kind == 0) exp_loc = code(r, c);
      wait_down_low("rnd_release", took);
      cyc(15);
      chk("rnd_pulses", pulses - p0, (kind == 0) ? 1 : 0);
      chk("rnd_loc", location, exp_loc);
    end

    chk("no_back2back", dbl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
